// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding the HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional: define MDU_EARLY_OUT_EN for early-terminating multiplies and zero-cycle divide-by-zero.
module mdu_hilo #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] mt_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CntW = $clog2(DATA_W);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [2*DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]     opb_q, opb_d;
    logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_q, neg_d;
    logic                  rneg_q, rneg_d;
    logic                  div0_q, div0_d;
    logic                  done_q, done_d;

    logic                  a_neg, b_neg;
    logic [DATA_W-1:0]     abs_a, abs_b;
    logic [DATA_W:0]       trial, diff;
    logic [2*DATA_W-1:0]   prod_fix;
    logic [DATA_W-1:0]     quo_fix, rem_fix;
    logic                  last_iter;

    // op[0]=1 selects the unsigned variants
    assign a_neg = ~op[0] & rs_data[DATA_W-1];
    assign b_neg = ~op[0] & rt_data[DATA_W-1];
    assign abs_a = a_neg ? (~rs_data + 1'b1) : rs_data;
    assign abs_b = b_neg ? (~rt_data + 1'b1) : rt_data;

    // Restoring step: acc holds {remainder, remaining dividend bits / quotient bits}
    assign trial = acc_q[2*DATA_W-1:DATA_W-1];
    assign diff  = trial - {1'b0, opb_q};

    assign prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix   = neg_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];
    assign rem_fix   = rneg_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1) : acc_q[2*DATA_W-1:DATA_W];
    assign last_iter = (cnt_q == CntW'(DATA_W - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    div0_d   = (rt_data == '0);
                    opb_d    = abs_b;
                    cnt_d    = '0;
                    if (op[1]) begin
                        acc_d   = {{DATA_W{1'b0}}, abs_a};
                        state_d = StDiv;
`ifdef MDU_EARLY_OUT_EN
                        // Remainder of a divide by zero is the dividend itself
                        if (rt_data == '0) begin
                            acc_d   = {abs_a, {DATA_W{1'b0}}};
                            state_d = StFix;
                        end
`endif
                    end else begin
                        acc_d   = '0;
                        mcand_d = {{DATA_W{1'b0}}, abs_a};
                        state_d = StMul;
                    end
                end else begin
                    if (mthi) hi_d = mt_data;
                    if (mtlo) lo_d = mt_data;
                end
            end
            StMul: begin
                acc_d   = acc_q + (opb_q[0] ? mcand_q : '0);
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (last_iter) state_d = StFix;
`ifdef MDU_EARLY_OUT_EN
                if (opb_q[DATA_W-1:1] == '0) state_d = StFix;
`endif
            end
            StDiv: begin
                if (!diff[DATA_W]) begin
                    acc_d = {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = div0_q ? '1 : quo_fix;
                end else begin
                    hi_d = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed vector table, corner sequences, random ops vs model.
module tb_mdu_hilo;

    localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = '0, rt_data = '0, mt_data = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_cnt = 0;

    mdu_hilo #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .mt_data (mt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cnt = busy_cnt + 1;
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    // Architectural result {hi, lo} computed with plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint p;
        int     sa, sb;
        model = '0;
        case (o)
            OpMult: begin
                p = longint'($signed(a)) * longint'($signed(b));
                model = p;
            end
            OpMultu: model = {32'b0, a} * {32'b0, b};
            OpDiv: begin
                sa = a;
                sb = b;
                if (b == 0) model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
                else model = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) model = {a, 32'hFFFF_FFFF};
                else model = {a % b, a / b};
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        rs_data = a;
        rt_data = b;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        busy_cnt = 0;
    endtask

    task automatic wait_done(input string name, input logic [63:0] exp);
        int guard = 0;
        while (!done && guard < 200) begin
            step();
            guard++;
        end
        if (!done) begin
            chk({name, ".timeout"}, 64'(done), 64'd1);
        end else begin
            chk(name, {hi, lo}, exp);
            chk({name, ".busy_at_done"}, 64'(busy), 64'd0);
`ifdef MDU_EARLY_OUT_EN
            chk({name, ".lat_le"}, 64'(cyc <= 33), 64'd1);
`else
            chk({name, ".latency"}, 64'(cyc), 64'd33);
            chk({name, ".busy_cycles"}, 64'(busy_cnt), 64'd33);
`endif
        end
    endtask

    initial begin
        vecs[0] = '{"multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{"mult_neg",  OpMult,  32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{"div_neg",   OpDiv,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3] = '{"divu_7_2",  OpDivu,  32'd7,         32'd2,        64'h0000_0001_0000_0003};
        vecs[4] = '{"divu_zero", OpDivu,  32'h1234,      32'd0,        64'h0000_1234_FFFF_FFFF};
        vecs[5] = '{"div_ovf",   OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};

        #12;
        chk("reset.hilo", {hi, lo}, 64'd0);
        chk("reset.busy_done", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].name, vecs[i].exp);
            step();
            chk({vecs[i].name, ".done_pulse"}, 64'(done), 64'd0);
        end

        // Signed divide by zero returns the negative dividend untouched
        issue(OpDiv, 32'hFFFF_FF00, 32'd0);
        wait_done("div_zero_neg", 64'hFFFF_FF00_FFFF_FFFF);
        step();

        // start and mthi during an operation are both ignored
        issue(OpMultu, 32'd2, 32'd3);
        while (cyc < 5) step();
        op = OpDivu; rs_data = 32'd99; rt_data = 32'd9; start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 10) step();
        mthi = 1'b1; mt_data = 32'hDEAD;
        step();
        mthi = 1'b0;
        wait_done("ignore_busy", 64'd6);

        // Back-to-back: new start in the done cycle
        step();
        issue(OpMultu, 32'd4, 32'd4);
        wait_done("b2b_first", 64'd16);
        issue(OpDivu, 32'd100, 32'd7);
        wait_done("b2b_second", {32'd2, 32'd14});
        step();

        // MTHI alone, then start beating a simultaneous MTHI
        mthi = 1'b1; mt_data = 32'h1111;
        step();
        mthi = 1'b0;
        chk("mthi_only", {hi, lo}, {32'h1111, 32'd14});
        mthi = 1'b1; mt_data = 32'hBEEF;
        issue(OpMultu, 32'd1, 32'd1);
        mthi = 1'b0;
        wait_done("start_wins", 64'd1);
        step();

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            issue(o, a, b);
            wait_done($sformatf("rand%0d_op%0d", i, o), model(o, a, b));
            step();
        end

        // MTHI+MTLO together, then reset mid-divide
        mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h5555;
        step();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both", {hi, lo}, {32'h5555, 32'h5555});
        issue(OpDiv, 32'd100, 32'd3);
        while (cyc < 12) step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid.hilo", {hi, lo}, 64'd0);
        chk("rst_mid.busy_done", {62'd0, busy, done}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        mtlo = 1'b1; mt_data = 32'hCAFE;
        step();
        mtlo = 1'b0;
        chk("mtlo_after_rst", {hi, lo}, {32'h0, 32'hCAFE});
        for (int k = 0; k < 40; k++) begin
            step();
            if (done || busy) break;
        end
        chk("no_stray_done", {62'd0, busy, done}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
